// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
//  Package     : uart_pkg
//  Description : Shared definitions for the UART transmit path. Holds the
//                byte-scheduler state encoding, the start-acknowledge
//                timeout and the default data width.
//                The GAP state exists only when TX_SCHED_GAP_EN is defined.
//  Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

    // Default byte width, shared with the TX FIFO.
    localparam int DEFAULT_DATA_WIDTH = 8;

    // Number of cycles after a start pulse that the scheduler waits for the
    // transmitter to raise busy before it assumes the byte already completed.
    localparam int ACK_TIMEOUT = 4;

    // Width of the acknowledge-timeout counter (must hold ACK_TIMEOUT-1).
    localparam int ACK_CNT_W = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;

    // Scheduler states.
`ifdef TX_SCHED_GAP_EN
    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_FETCH     = 3'd1,
        ST_LOAD      = 3'd2,
        ST_WAIT_ACK  = 3'd3,
        ST_WAIT_DONE = 3'd4,
        ST_GAP       = 3'd5
    } tx_sched_state_t;
`else
    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_FETCH     = 3'd1,
        ST_LOAD      = 3'd2,
        ST_WAIT_ACK  = 3'd3,
        ST_WAIT_DONE = 3'd4
    } tx_sched_state_t;
`endif

endpackage : uart_pkg
`default_nettype wire

// File: rtl/uart_tx_sched.sv
`default_nettype none
// ============================================================================
//  Module      : uart_tx_sched
//  Description : Byte scheduler between the TX fifo_sync and the UART
//                serializer. Pops one byte, registers it, issues a single
//                cycle start to the transmitter and waits for the
//                transmitter to finish before popping the next byte.
//                Reports activity and a wrapping count of bytes handed off.
//
//  Optional    : TX_SCHED_GAP_EN - when defined, GAP_CYCLES idle clocks are
//                inserted after every byte (GAP state, o_busy stays high).
//                When undefined there is no GAP state and no gap counter.
//
//  Ports       :
//    i_clk         in   1           system clock
//    i_rstn        in   1           asynchronous active-low reset
//    i_enable      in   1           scheduling enable, sampled in IDLE only
//    o_fifo_rd     out  1           FIFO read strobe, single-cycle pulse
//    i_fifo_dout   in   DATA_WIDTH  FIFO read data, valid cycle after pop
//    i_fifo_empty  in   1           FIFO empty flag
//    o_tx_start    out  1           transmitter start, single-cycle pulse
//    o_tx_data     out  DATA_WIDTH  registered byte to transmit
//    i_tx_busy     in   1           transmitter busy
//    o_busy        out  1           high in every state except IDLE
//    o_sent_count  out  CNT_WIDTH   bytes handed off, wrapping
//
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_sched
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int CNT_WIDTH  = 16,
    parameter int GAP_CYCLES = 16
) (
    input  logic                  i_clk,
    input  logic                  i_rstn,
    input  logic                  i_enable,
    output logic                  o_fifo_rd,
    input  logic [DATA_WIDTH-1:0] i_fifo_dout,
    input  logic                  i_fifo_empty,
    output logic                  o_tx_start,
    output logic [DATA_WIDTH-1:0] o_tx_data,
    input  logic                  i_tx_busy,
    output logic                  o_busy,
    output logic [CNT_WIDTH-1:0]  o_sent_count
);

    // ------------------------------------------------------------------------
    // Elaboration-time parameter sanity check
    // ------------------------------------------------------------------------
    if (GAP_CYCLES < 0) begin : g_gap_param_chk
        $error("uart_tx_sched: GAP_CYCLES must be non-negative");
    end

    // ------------------------------------------------------------------------
    // Declarations
    // ------------------------------------------------------------------------
    tx_sched_state_t         r_state;
    tx_sched_state_t         w_state_nxt;
    tx_sched_state_t         w_done_nxt;

    logic [ACK_CNT_W-1:0]    r_ack_cnt;
    logic                    w_ack_expired;

    logic [DATA_WIDTH-1:0]   r_tx_data;
    logic [CNT_WIDTH-1:0]    r_sent_cnt;

    logic                    w_fifo_rd;
    logic                    w_tx_start;
    logic                    w_busy;

    // ------------------------------------------------------------------------
    // Inter-byte gap (optional)
    // ------------------------------------------------------------------------
`ifdef TX_SCHED_GAP_EN
    localparam int GAP_W = (GAP_CYCLES > 2) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [GAP_W-1:0] GAP_LOAD =
        GAP_W'((GAP_CYCLES > 0) ? (GAP_CYCLES - 1) : 0);

    logic [GAP_W-1:0]        r_gap_cnt;
    logic                    w_gap_done;

    // A zero-length gap bypasses the GAP state entirely.
    assign w_done_nxt = (GAP_CYCLES == 0) ? ST_IDLE : ST_GAP;
    assign w_gap_done = (r_gap_cnt == '0);

    // Loaded on the way into GAP so the state lasts exactly GAP_CYCLES clocks.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            r_gap_cnt <= '0;
        end else if ((r_state == ST_WAIT_DONE) && (w_state_nxt == ST_GAP)) begin
            r_gap_cnt <= GAP_LOAD;
        end else if ((r_state == ST_GAP) && !w_gap_done) begin
            r_gap_cnt <= r_gap_cnt - 1'b1;
        end
    end
`else
    assign w_done_nxt = ST_IDLE;
`endif

    // ------------------------------------------------------------------------
    // Start-acknowledge timeout
    // ------------------------------------------------------------------------
    // Counts cycles spent in WAIT_ACK. A transmitter that finishes before its
    // busy flag is ever seen would otherwise leave the scheduler stuck here.
    assign w_ack_expired = (r_ack_cnt == ACK_CNT_W'(ACK_TIMEOUT - 1));

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            r_ack_cnt <= '0;
        end else if (r_state == ST_WAIT_ACK) begin
            r_ack_cnt <= r_ack_cnt + 1'b1;
        end else begin
            r_ack_cnt <= '0;
        end
    end

    // ------------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------------
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                // Empty is only looked at here, so a pop never underruns.
                if (i_enable && !i_fifo_empty) begin
                    w_state_nxt = ST_FETCH;
                end
            end
            ST_FETCH: begin
                w_state_nxt = ST_LOAD;
            end
            ST_LOAD: begin
                if (!i_tx_busy) begin
                    w_state_nxt = ST_WAIT_ACK;
                end
            end
            ST_WAIT_ACK: begin
                if (i_tx_busy || w_ack_expired) begin
                    w_state_nxt = ST_WAIT_DONE;
                end
            end
            ST_WAIT_DONE: begin
                if (!i_tx_busy) begin
                    w_state_nxt = w_done_nxt;
                end
            end
`ifdef TX_SCHED_GAP_EN
            ST_GAP: begin
                if (w_gap_done) begin
                    w_state_nxt = ST_IDLE;
                end
            end
`endif
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // FSM: output logic
    // ------------------------------------------------------------------------
    // The pop strobe is qualified with the reset input so that it stays low
    // while reset is held, even with enable high and the FIFO non-empty.
    always_comb begin
        w_fifo_rd  = 1'b0;
        w_tx_start = 1'b0;
        w_busy     = 1'b1;
        case (r_state)
            ST_IDLE: begin
                w_busy    = 1'b0;
                w_fifo_rd = i_rstn && i_enable && !i_fifo_empty;
            end
            ST_LOAD: begin
                w_tx_start = !i_tx_busy;
            end
            default: begin
                w_busy = 1'b1;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Byte holding register and sent counter
    // ------------------------------------------------------------------------
    // FIFO data is valid the cycle after the pop, i.e. while in FETCH. The
    // register then holds the byte through the whole transmission.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            r_tx_data <= '0;
        end else if (r_state == ST_FETCH) begin
            r_tx_data <= i_fifo_dout;
        end
    end

    // Free-running wrap on overflow; counts start pulses.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            r_sent_cnt <= '0;
        end else if (w_tx_start) begin
            r_sent_cnt <= r_sent_cnt + 1'b1;
        end
    end

    // ------------------------------------------------------------------------
    // Output assignments
    // ------------------------------------------------------------------------
    assign o_fifo_rd    = w_fifo_rd;
    assign o_tx_start   = w_tx_start;
    assign o_tx_data    = r_tx_data;
    assign o_busy       = w_busy;
    assign o_sent_count = r_sent_cnt;

endmodule : uart_tx_sched
`default_nettype wire

// File: doc/uart_tx_sched.md
Name: uart_tx_sched

Overview:
- Drains bytes from a fifo_sync instance and feeds them one at a time to the UART transmitter.
- Pops the FIFO, holds the byte stable, issues a single-cycle start and waits for the transmitter to finish before the next pop.
- Sits between the TX fifo_sync and the serializer, and reports activity and a sent-byte count to the status logic.

Parameters:
- DATA_WIDTH, 8, byte width; matches the FIFO data width.
- CNT_WIDTH, 16, width of the sent-byte counter.
- GAP_CYCLES, 16, idle clocks inserted between bytes. Used only with TX_SCHED_GAP_EN.

Ports:
- i_clk  in  1  system clock.
- i_rstn  in  1  asynchronous active-low reset.
- i_enable  in  1  scheduling enable; sampled in IDLE only.
- o_fifo_rd  out  1  FIFO read strobe, single-cycle pulse.
- i_fifo_dout  in  DATA_WIDTH  FIFO read data; valid the cycle after o_fifo_rd.
- i_fifo_empty  in  1  FIFO empty flag.
- o_tx_start  out  1  transmitter start, single-cycle pulse.
- o_tx_data  out  DATA_WIDTH  byte to transmit; registered, stable from LOAD until return to IDLE.
- i_tx_busy  in  1  transmitter busy; rises within 1..2 cycles of start and falls when the stop bit ends.
- o_busy  out  1  high in every state except IDLE.
- o_sent_count  out  CNT_WIDTH  bytes handed off, wrapping.

Behaviour:
- Clock and reset: single clock i_clk; reset i_rstn is asynchronous, active-low.
- Reset values: all outputs 0, state IDLE.
- Reset mid-operation aborts immediately. A byte already popped is lost; there is no re-queue.
- States: IDLE, FETCH, LOAD, WAIT_ACK, WAIT_DONE, and GAP (gap state only with the macro).
- IDLE:
  - If i_enable && !i_fifo_empty: assert o_fifo_rd for exactly 1 cycle, go to FETCH.
  - Otherwise stay in IDLE.
- FETCH: capture i_fifo_dout into o_tx_data, go to LOAD.
  - Fixed latency: pop at cycle N, data registered at N+1.
- LOAD: if !i_tx_busy, assert o_tx_start for 1 cycle, increment o_sent_count, go to WAIT_ACK. Otherwise hold in LOAD.
- WAIT_ACK:
  - On i_tx_busy=1, go to WAIT_DONE.
  - If busy has not risen within 4 cycles of start, go to WAIT_DONE anyway. This prevents a deadlock on a transmitter that completes instantly.
- WAIT_DONE: on i_tx_busy=0, go to IDLE (or to GAP when the macro is defined).
- Minimum pop-to-pop spacing is 5 cycles plus transmission time. The next byte is never popped until the previous one has finished.
- i_enable deasserted mid-byte: the current byte completes, then the block halts in IDLE.
- i_fifo_empty is checked only in IDLE. A pop is never issued when empty, so FIFO underrun is impossible.
- o_sent_count wraps from 2^CNT_WIDTH-1 to 0 without saturating.
- o_fifo_rd and o_tx_start are never high in the same cycle, and never high for two consecutive cycles.

Optional Feature:
- Macro: TX_SCHED_GAP_EN.
- Defined:
  - WAIT_DONE goes to GAP, which loads a down-counter with GAP_CYCLES-1 and returns to IDLE when the count reaches 0.
  - o_busy stays high during GAP.
  - GAP_CYCLES=0 skips GAP.
- Undefined: no GAP state or counter; WAIT_DONE goes directly to IDLE.

Decomposition:
- Shared package uart_pkg holds:
  - the state enum typedef tx_sched_state_t;
  - the constant ACK_TIMEOUT=4;
  - the default DATA_WIDTH.
- Single module with no sub-module.
- The gap counter is inline, under the macro guard.

Test Plan:
- Single byte: FIFO holds 0xA5, enable=1.
  - o_fifo_rd pulses once.
  - Cycle+2: o_tx_data=0xA5 and o_tx_start pulses.
  - o_sent_count=1; o_busy falls 1 cycle after the model drops busy.
- Burst: 8 bytes 0x01..0x08 written (FIFO full).
  - Transmitter model receives 0x01..0x08 in order with exactly 8 pops.
  - o_fifo_rd never pulses while i_fifo_empty=1; final o_sent_count=8.
- Back-pressure: i_tx_busy held high externally before start.
  - Block holds in LOAD with o_tx_data stable and no o_tx_start.
  - Start fires 1 cycle after busy releases.
- Enable drop: 3 bytes queued, i_enable cleared during the first byte's WAIT_DONE.
  - Only 1 byte sent; the FIFO retains 2; the block idles.
- Timeout and reset: model never asserts busy, so the block leaves WAIT_ACK after 4 cycles.
  - Separately, i_rstn pulsed low in WAIT_DONE: all outputs return to 0 asynchronously, state returns to IDLE, o_sent_count=0.
- Gap (TX_SCHED_GAP_EN defined, GAP_CYCLES=16): 2 bytes queued.
  - The second o_fifo_rd occurs exactly 16 cycles after the first byte's busy falls, plus 1 cycle for the IDLE evaluation.
  - Counter wrap check: CNT_WIDTH=4, send 17 bytes, giving o_sent_count=1.
